// File: rtl/gelato_warp_scheduler.sv
// Per-SM warp scheduler: round-robin pick among ready warps, single-entry issue
// register with valid/ready handoff, per-warp in-flight limiting released by writeback.

module gelato_warp_slot #(
    parameter int MAX_INFLIGHT = 2,
    parameter int CNT_W        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             avail,
    output logic             err
);
    logic dec_ok;

    // A writeback against an empty counter is bogus: it is flagged and ignored,
    // so a coincident grant still counts.
    assign dec_ok = dec & (cnt != '0);
    assign err    = dec & (cnt == '0);
    assign avail  = cnt < CNT_W'(MAX_INFLIGHT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && !dec_ok)
            cnt <= cnt + CNT_W'(1);
        else if (dec_ok && !inc)
            cnt <= cnt - CNT_W'(1);
    end
endmodule

module gelato_warp_scheduler #(
    parameter int WARP_NUM     = 4,
    parameter int INST_WIDTH   = 32,
    parameter int MAX_INFLIGHT = 2,
    parameter int WID_W        = $clog2(WARP_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic [WARP_NUM-1:0]            buf_valid,
    input  logic [WARP_NUM*INST_WIDTH-1:0] buf_inst,
    output logic [WARP_NUM-1:0]            buf_caught,
    input  logic [WARP_NUM-1:0]            warp_active,
    output logic                           issue_valid,
    output logic [WID_W-1:0]               issue_warp,
    output logic [INST_WIDTH-1:0]          issue_inst,
    input  logic                           issue_ready,
    input  logic                           wb_valid,
    input  logic [WID_W-1:0]               wb_warp,
    output logic                           sched_err
);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [WID_W-1:0]      warp;
        logic [INST_WIDTH-1:0] inst;
    } issue_t;

    logic [WARP_NUM-1:0][CNT_W-1:0] cnt;
    logic [WARP_NUM-1:0]            avail;
    logic [WARP_NUM-1:0]            slot_err;
    logic [WARP_NUM-1:0]            eligible;
    logic [WARP_NUM-1:0]            grant_oh;
    logic [WID_W-1:0]               ptr;
    logic [WID_W-1:0]               grant;
    logic [WID_W-1:0]               idx;
    logic                           any;
    logic                           xfer;
    logic                           load;
    issue_t                         iss_q;

    assign eligible = buf_valid & warp_active & avail;
    assign xfer     = rdy & issue_valid & issue_ready;
    assign load     = rdy & (~issue_valid | xfer) & any;

    // Scan ptr+1 .. ptr+WARP_NUM; WARP_NUM is a power of two so the sum wraps.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 1; k <= WARP_NUM; k++) begin
            idx = ptr + WID_W'(k);
            if (!any && eligible[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < WARP_NUM; i++) begin : g_warp
            assign grant_oh[i]   = load & (grant == WID_W'(i));
            assign buf_caught[i] = grant_oh[i] & ~rst;

            gelato_warp_slot #(
                .MAX_INFLIGHT (MAX_INFLIGHT),
                .CNT_W        (CNT_W)
            ) u_slot (
                .clk   (clk),
                .rst   (rst),
                .inc   (grant_oh[i]),
                .dec   (wb_valid & (wb_warp == WID_W'(i))),
                .cnt   (cnt[i]),
                .avail (avail[i]),
                .err   (slot_err[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= 1'b0;
            iss_q       <= '0;
            ptr         <= WID_W'(WARP_NUM - 1);
        end else if (load) begin
            issue_valid <= 1'b1;
            iss_q.warp  <= grant;
            iss_q.inst  <= buf_inst[grant*INST_WIDTH +: INST_WIDTH];
            ptr         <= grant;
        end else if (xfer) begin
            issue_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sched_err <= 1'b0;
        else if (|slot_err)
            sched_err <= 1'b1;
    end

    assign issue_warp = iss_q.warp;
    assign issue_inst = iss_q.inst;
endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Directed bench for gelato_warp_scheduler (4 warps, 32-bit inst, 2 in flight).

module tb_gelato_warp_scheduler;
    localparam int W  = 4;
    localparam int IW = 32;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy, issue_ready, wb_valid;
    logic [W-1:0]  buf_valid, warp_active, buf_caught;
    logic [W*IW-1:0] buf_inst;
    logic          issue_valid, sched_err;
    logic [WW-1:0] issue_warp, wb_warp;
    logic [IW-1:0] issue_inst;
    logic [IW-1:0] inst_of [W];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        buf_inst = '0;
        for (int i = 0; i < W; i++) buf_inst[i*IW +: IW] = inst_of[i];
    end

    gelato_warp_scheduler #(.WARP_NUM(4), .INST_WIDTH(32), .MAX_INFLIGHT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .buf_valid   (buf_valid),
        .buf_inst    (buf_inst),
        .buf_caught  (buf_caught),
        .warp_active (warp_active),
        .issue_valid (issue_valid),
        .issue_warp  (issue_warp),
        .issue_inst  (issue_inst),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_warp     (wb_warp),
        .sched_err   (sched_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < W; i++) inst_of[i] = 32'hC0DE_0000 + 32'(i);
        rst = 1'b1; rdy = 1'b1; buf_valid = '1; warp_active = '1;
        issue_ready = 1'b1; wb_valid = 1'b0; wb_warp = '0;
        #1;
        total++; if (buf_caught !== 4'b0000) begin bad++; $display("FAIL reset_caught got=%b exp=0000", buf_caught); end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", issue_valid); end
        total++; if (issue_warp !== 2'd0) begin bad++; $display("FAIL reset_warp got=%0d exp=0", issue_warp); end
        total++; if (issue_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", issue_inst); end
        total++; if (sched_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", sched_err); end
        total++; if (buf_caught !== 4'b0000) begin bad++; $display("FAIL reset_caught2 got=%b exp=0000", buf_caught); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp_c;
        for (int k = 0; k < 8; k++) begin
            wb_valid = (k > 0);
            wb_warp  = WW'((k + 3) % 4);
            exp_c    = 4'b0001 << (k % 4);
            #1;
            total++; if (buf_caught !== exp_c) begin bad++; $display("FAIL rr_caught k=%0d got=%b exp=%b", k, buf_caught, exp_c); end
            tick();
            total++; if (issue_valid !== 1'b1 || issue_warp !== WW'(k % 4)) begin bad++; $display("FAIL rr_warp k=%0d got=%b/%0d exp=1/%0d", k, issue_valid, issue_warp, k % 4); end
            total++; if (issue_inst !== inst_of[k % 4]) begin bad++; $display("FAIL rr_inst k=%0d got=%h exp=%h", k, issue_inst, inst_of[k % 4]); end
        end
        buf_valid = '0; wb_valid = 1'b1; wb_warp = 2'd3;
        #1;
        total++; if (buf_caught !== 4'b0000) begin bad++; $display("FAIL rr_drain_caught got=%b exp=0000", buf_caught); end
        tick();
        wb_valid = 1'b0;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rr_drain_valid got=%b exp=0", issue_valid); end
    endtask

    task automatic test_stall();
        buf_valid = 4'b0100;
        #1;
        total++; if (buf_caught !== 4'b0100) begin bad++; $display("FAIL stall_first_caught got=%b exp=0100", buf_caught); end
        tick();
        inst_of[2] = 32'hBEEF_0002;
        issue_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            total++; if (buf_caught !== 4'b0000) begin bad++; $display("FAIL stall_caught s=%0d got=%b exp=0000", s, buf_caught); end
            tick();
            total++; if (issue_valid !== 1'b1 || issue_warp !== 2'd2 || issue_inst !== 32'hC0DE_0002) begin
                bad++; $display("FAIL stall_hold s=%0d got=%b/%0d/%h exp=1/2/c0de0002", s, issue_valid, issue_warp, issue_inst);
            end
        end
        issue_ready = 1'b1;
        #1;
        total++; if (buf_caught !== 4'b0100) begin bad++; $display("FAIL stall_resume_caught got=%b exp=0100", buf_caught); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_inst !== 32'hBEEF_0002) begin bad++; $display("FAIL stall_resume_inst got=%b/%h exp=1/beef0002", issue_valid, issue_inst); end
        buf_valid = '0; wb_valid = 1'b1; wb_warp = 2'd2;
        tick();
        tick();
        wb_valid = 1'b0;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL stall_drain_valid got=%b exp=0", issue_valid); end
    endtask

    task automatic test_inflight();
        buf_valid = 4'b0010;
        #1;
        total++; if (buf_caught !== 4'b0010) begin bad++; $display("FAIL infl_c0 got=%b exp=0010", buf_caught); end
        tick();
        #1;
        total++; if (buf_caught !== 4'b0010) begin bad++; $display("FAIL infl_c1 got=%b exp=0010", buf_caught); end
        tick();
        #1;
        total++; if (buf_caught !== 4'b0000) begin bad++; $display("FAIL infl_limit got=%b exp=0000", buf_caught); end
        tick();
        #1;
        total++; if (buf_caught !== 4'b0000 || issue_valid !== 1'b0) begin bad++; $display("FAIL infl_idle got=%b/%b exp=0000/0", buf_caught, issue_valid); end
        wb_valid = 1'b1; wb_warp = 2'd1;
        #1;
        total++; if (buf_caught !== 4'b0000) begin bad++; $display("FAIL infl_wb_same_cycle got=%b exp=0000", buf_caught); end
        tick();
        wb_valid = 1'b0;
        #1;
        total++; if (buf_caught !== 4'b0010) begin bad++; $display("FAIL infl_wb_next got=%b exp=0010", buf_caught); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_warp !== 2'd1) begin bad++; $display("FAIL infl_reissue got=%b/%0d exp=1/1", issue_valid, issue_warp); end
        buf_valid = '0; wb_valid = 1'b1; wb_warp = 2'd1;
        tick();
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_same_cycle();
        buf_valid = 4'b1000;
        #1;
        total++; if (buf_caught !== 4'b1000) begin bad++; $display("FAIL same_c0 got=%b exp=1000", buf_caught); end
        tick();
        wb_valid = 1'b1; wb_warp = 2'd3;
        #1;
        total++; if (buf_caught !== 4'b1000) begin bad++; $display("FAIL same_c1 got=%b exp=1000", buf_caught); end
        tick();
        wb_valid = 1'b0;
        #1;
        total++; if (buf_caught !== 4'b1000) begin bad++; $display("FAIL same_cnt_kept got=%b exp=1000", buf_caught); end
        tick();
        #1;
        total++; if (buf_caught !== 4'b0000) begin bad++; $display("FAIL same_limit got=%b exp=0000", buf_caught); end
        buf_valid = '0; wb_valid = 1'b1; wb_warp = 2'd3;
        tick();
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_err();
        wb_valid = 1'b1; wb_warp = 2'd0;
        #1;
        total++; if (sched_err !== 1'b0) begin bad++; $display("FAIL err_before got=%b exp=0", sched_err); end
        tick();
        wb_valid = 1'b0;
        total++; if (sched_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", sched_err); end
        tick();
        tick();
        total++; if (sched_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", sched_err); end
        buf_valid = 4'b0001;
        #1;
        total++; if (buf_caught !== 4'b0001) begin bad++; $display("FAIL err_cnt_c0 got=%b exp=0001", buf_caught); end
        tick();
        #1;
        total++; if (buf_caught !== 4'b0001) begin bad++; $display("FAIL err_cnt_c1 got=%b exp=0001", buf_caught); end
        tick();
        #1;
        total++; if (buf_caught !== 4'b0000) begin bad++; $display("FAIL err_cnt_limit got=%b exp=0000", buf_caught); end
        buf_valid = '0; wb_valid = 1'b1; wb_warp = 2'd0;
        tick();
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_freeze();
        buf_valid = '1;
        #1;
        total++; if (buf_caught !== 4'b0010) begin bad++; $display("FAIL frz_c0 got=%b exp=0010", buf_caught); end
        tick();
        wb_valid = 1'b1; wb_warp = 2'd1;
        #1;
        total++; if (buf_caught !== 4'b0100) begin bad++; $display("FAIL frz_c1 got=%b exp=0100", buf_caught); end
        tick();
        wb_valid = 1'b0; rdy = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            total++; if (buf_caught !== 4'b0000) begin bad++; $display("FAIL frz_caught s=%0d got=%b exp=0000", s, buf_caught); end
            tick();
            total++; if (issue_valid !== 1'b1 || issue_warp !== 2'd2 || issue_inst !== inst_of[2]) begin
                bad++; $display("FAIL frz_hold s=%0d got=%b/%0d/%h exp=1/2/%h", s, issue_valid, issue_warp, issue_inst, inst_of[2]);
            end
        end
        rdy = 1'b1; wb_valid = 1'b1; wb_warp = 2'd2;
        #1;
        total++; if (buf_caught !== 4'b1000) begin bad++; $display("FAIL frz_resume got=%b exp=1000", buf_caught); end
        tick();
        wb_valid = 1'b0;
        total++; if (issue_warp !== 2'd3 || issue_inst !== inst_of[3]) begin bad++; $display("FAIL frz_next got=%0d/%h exp=3/%h", issue_warp, issue_inst, inst_of[3]); end
        rst = 1'b1;
        #1;
        total++; if (issue_valid !== 1'b0 || buf_caught !== 4'b0000) begin bad++; $display("FAIL frz_rst got=%b/%b exp=0/0000", issue_valid, buf_caught); end
        total++; if (issue_inst !== 32'h0 || sched_err !== 1'b0) begin bad++; $display("FAIL frz_rst_regs got=%h/%b exp=0/0", issue_inst, sched_err); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_inflight();
        test_same_cycle();
        test_err();
        test_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
